julia_uart_cmd_rx: RTL and testbench

- Host-to-board command path for the Julia set engine: 8N1 UART receiver plus frame parser driven from the board RXD pin.
- Loads the Julia constant c (real/imag) and the iteration limit from a PC, replacing the slide-switch selection.
- Sits between the top-level RXD pin and the compute engine's constant registers.
- Produces a one-cycle update strobe when a validated frame commits.

---
 rtl/julia_uart_cmd_rx_if.sv | 23 ++
 rtl/julia_uart_cmd_rx.sv | 184 ++++++++++++++++++
 tb/tb_julia_uart_cmd_rx.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/julia_uart_cmd_rx_if.sv
// Julia command receiver bus: serial input plus the constant/iteration outputs.
// The slave side is the receiver; the master side is the host/consumer view.
interface julia_uart_cmd_rx_if;
   logic        uart_rxd;
   logic [15:0] c_real;
   logic [15:0] c_imag;
   logic [7:0]  max_iter;
   logic        cfg_update;
   logic        rx_err;
   logic        busy;

   modport master (
      output uart_rxd,
      input  c_real, c_imag, max_iter,
      input  cfg_update, rx_err, busy
   );

   modport slave (
      input  uart_rxd,
      output c_real, c_imag, max_iter,
      output cfg_update, rx_err, busy
   );
endinterface

// File: rtl/julia_uart_cmd_rx.sv
// 8N1 UART receiver and A5/CMD/payload/CHK frame parser that loads the
// Julia constant c and the iteration limit from a host PC.
module julia_uart_cmd_rx #(
   parameter int          CLKS_PER_BIT = 434,
   parameter int          TIMEOUT_CLKS = 50000,
   parameter logic [15:0] C_RE_INIT    = 16'hE000,
   parameter logic [15:0] C_IM_INIT    = 16'h2000,
   parameter logic [7:0]  ITER_INIT    = 8'd64
) (
   input logic               clk,
   input logic               reset,
   julia_uart_cmd_rx_if.slave bus
);
   localparam int CW   = $clog2(CLKS_PER_BIT);
   localparam int TW   = $clog2(TIMEOUT_CLKS + 1);
   localparam int HALF = CLKS_PER_BIT / 2;

   typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bstate_t;
   typedef enum logic [1:0] {P_IDLE, P_CMD, P_PAYLOAD, P_CHECK} pstate_t;

   logic [1:0]  r_rst;
   logic        w_rst_n;
   logic [1:0]  r_sync;
   logic        r_rx_q;
   logic        w_rx;
   logic        w_fall;
   bstate_t     r_bstate, w_bnext;
   pstate_t     r_pstate, w_pnext;
   logic [CW-1:0] r_cnt;
   logic [2:0]  r_bidx;
   logic [7:0]  r_shift;
   logic        w_half, w_full;
   logic        w_byte_valid, w_frame_err;
   logic [7:0]  w_byte;
   logic [2:0]  r_pcnt;
   logic [7:0]  r_xor;
   logic [31:0] r_stage;
   logic        r_is_c;
   logic [TW-1:0] r_tmo;
   logic        w_timeout, w_cmd_err, w_chk_err, w_commit;
   logic [15:0] r_c_real, r_c_imag;
   logic [7:0]  r_max_iter;
   logic        r_cfg_update, r_rx_err;

   // Async assert, sync release of the internal reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_rst <= 2'b00;
      else        r_rst <= {r_rst[0], 1'b1};
   end
   assign w_rst_n = r_rst[1];

   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_sync <= 2'b11;
         r_rx_q <= 1'b1;
      end else begin
         r_sync <= {r_sync[0], bus.uart_rxd};
         r_rx_q <= r_sync[1];
      end
   end
   assign w_rx   = r_sync[1];
   assign w_fall = r_rx_q & ~w_rx;
   assign w_half = (r_cnt == CW'(HALF - 1));
   assign w_full = (r_cnt == CW'(CLKS_PER_BIT - 1));
   assign w_byte = r_shift;

   always_comb begin
      w_bnext      = r_bstate;
      w_byte_valid = 1'b0;
      w_frame_err  = 1'b0;
      unique case (r_bstate)
         B_IDLE:  if (w_fall) w_bnext = B_START;
         B_START: if (w_half) w_bnext = w_rx ? B_IDLE : B_DATA;
         B_DATA:  if (w_full && r_bidx == 3'd7) w_bnext = B_STOP;
         B_STOP: begin
            if (w_full) begin
               w_bnext      = B_IDLE;
               w_byte_valid = w_rx;
               w_frame_err  = ~w_rx;
            end
         end
         default: w_bnext = B_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_bstate <= B_IDLE;
         r_cnt    <= '0;
         r_bidx   <= '0;
         r_shift  <= '0;
      end else begin
         r_bstate <= w_bnext;
         if (r_bstate == B_IDLE || w_bnext != r_bstate ||
             (r_bstate == B_DATA && w_full))
            r_cnt <= '0;
         else
            r_cnt <= r_cnt + 1'b1;
         if (r_bstate == B_START) r_bidx <= '0;
         if (r_bstate == B_DATA && w_full) begin
            r_shift <= {w_rx, r_shift[7:1]};
            r_bidx  <= r_bidx + 3'd1;
         end
      end
   end

   // A framing error in the same cycle already forces IDLE with one pulse
   assign w_timeout = (r_pstate != P_IDLE) && !w_byte_valid && !w_frame_err &&
                      (r_tmo == TW'(TIMEOUT_CLKS - 1));

   always_comb begin
      w_pnext   = r_pstate;
      w_cmd_err = 1'b0;
      w_chk_err = 1'b0;
      w_commit  = 1'b0;
      if (w_frame_err || w_timeout) begin
         w_pnext = P_IDLE;
      end else if (w_byte_valid) begin
         unique case (r_pstate)
            P_IDLE: if (w_byte == 8'hA5) w_pnext = P_CMD;
            P_CMD: begin
               unique case (1'b1)
                  (w_byte == 8'h01),
                  (w_byte == 8'h02): w_pnext = P_PAYLOAD;
                  default: begin
                     w_pnext   = P_IDLE;
                     w_cmd_err = 1'b1;
                  end
               endcase
            end
            P_PAYLOAD: if (r_pcnt == 3'd1) w_pnext = P_CHECK;
            P_CHECK: begin
               w_pnext   = P_IDLE;
               w_commit  = (w_byte == r_xor);
               w_chk_err = (w_byte != r_xor);
            end
            default: w_pnext = P_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_pstate     <= P_IDLE;
         r_pcnt       <= '0;
         r_xor        <= '0;
         r_stage      <= '0;
         r_is_c       <= 1'b0;
         r_tmo        <= '0;
         r_c_real     <= C_RE_INIT;
         r_c_imag     <= C_IM_INIT;
         r_max_iter   <= ITER_INIT;
         r_cfg_update <= 1'b0;
         r_rx_err     <= 1'b0;
      end else begin
         r_pstate <= w_pnext;
         if (r_pstate == P_IDLE || w_byte_valid) r_tmo <= '0;
         else                                    r_tmo <= r_tmo + 1'b1;
         if (w_byte_valid && r_pstate == P_CMD) begin
            r_xor  <= w_byte;
            r_is_c <= (w_byte == 8'h01);
            r_pcnt <= (w_byte == 8'h01) ? 3'd4 : 3'd1;
         end
         if (w_byte_valid && r_pstate == P_PAYLOAD) begin
            r_stage <= {r_stage[23:0], w_byte};
            r_xor   <= r_xor ^ w_byte;
            r_pcnt  <= r_pcnt - 3'd1;
         end
         if (w_commit) begin
            if (r_is_c) {r_c_real, r_c_imag} <= r_stage;
            else        r_max_iter           <= r_stage[7:0];
         end
         r_cfg_update <= w_commit;
         r_rx_err     <= w_frame_err | w_timeout | w_cmd_err | w_chk_err;
      end
   end

   assign bus.c_real     = r_c_real;
   assign bus.c_imag     = r_c_imag;
   assign bus.max_iter   = r_max_iter;
   assign bus.cfg_update = r_cfg_update;
   assign bus.rx_err     = r_rx_err;
   assign bus.busy       = (r_pstate != P_IDLE);
endmodule

// File: tb/tb_julia_uart_cmd_rx.sv
// Scoreboard bench: frame-level reference model pushes expected pulses,
// a negedge monitor pops and compares whenever the DUT pulses.
module tb_julia_uart_cmd_rx;
   localparam int CPB = 16;
   localparam int TMO = 1000;
   localparam logic [15:0] RE0 = 16'hE000;
   localparam logic [15:0] IM0 = 16'h2000;
   localparam logic [7:0]  IT0 = 8'd64;

   typedef struct {
      bit          upd;
      logic [15:0] re;
      logic [15:0] im;
      logic [7:0]  it;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   julia_uart_cmd_rx_if bus();

   julia_uart_cmd_rx #(
      .CLKS_PER_BIT(CPB),
      .TIMEOUT_CLKS(TMO)
   ) dut (
      .clk  (clk),
      .reset(rst_n),
      .bus  (bus)
   );

   exp_t        exp_q[$];
   exp_t        me;
   int          n_chk = 0;
   int          n_pass = 0;
   int          n_pulse = 0;
   logic [15:0] m_re = RE0;
   logic [15:0] m_im = IM0;
   logic [7:0]  m_it = IT0;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   always @(negedge clk) begin
      if (rst_n && (bus.cfg_update || bus.rx_err)) begin
         n_pulse++;
         check("update_err_exclusive", 32'(bus.cfg_update & bus.rx_err), 0);
         if (exp_q.size() == 0) begin
            check("unexpected_pulse", {30'd0, bus.cfg_update, bus.rx_err}, 0);
         end else begin
            me = exp_q.pop_front();
            check("pulse_kind", {30'd0, bus.cfg_update, bus.rx_err},
                  me.upd ? 32'd2 : 32'd1);
            if (me.upd) begin
               check("upd_c_real", 32'(bus.c_real), 32'(me.re));
               check("upd_c_imag", 32'(bus.c_imag), 32'(me.im));
               check("upd_max_iter", 32'(bus.max_iter), 32'(me.it));
            end
         end
      end
   end

   // Reference: decide a whole frame's outcome from the frame rules
   task automatic model_frame(input logic [7:0] f[$]);
      exp_t e;
      logic [7:0] x;
      int n;
      e.upd = 1'b0;
      if (f[1] != 8'h01 && f[1] != 8'h02) begin
         e.upd = 1'b0;
      end else begin
         n = (f[1] == 8'h01) ? 4 : 1;
         x = f[1];
         for (int i = 0; i < n; i++) x = x ^ f[2 + i];
         if (f[2 + n] == x) begin
            e.upd = 1'b1;
            if (n == 4) begin
               m_re = {f[2], f[3]};
               m_im = {f[4], f[5]};
            end else begin
               m_it = f[2];
            end
         end
      end
      e.re = m_re;
      e.im = m_im;
      e.it = m_it;
      exp_q.push_back(e);
   endtask

   task automatic push_err();
      exp_t e;
      e.upd = 1'b0;
      e.re = m_re;
      e.im = m_im;
      e.it = m_it;
      exp_q.push_back(e);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      @(negedge clk);
      bus.uart_rxd = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         bus.uart_rxd = b[i];
         repeat (CPB) @(negedge clk);
      end
      bus.uart_rxd = stop;
      repeat (CPB) @(negedge clk);
      bus.uart_rxd = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] f[$]);
      foreach (f[i]) send_byte(f[i], 1'b1);
   endtask

   task automatic post_check(input string tag);
      repeat (6) @(negedge clk);
      check({tag, "_c_real"}, 32'(bus.c_real), 32'(m_re));
      check({tag, "_c_imag"}, 32'(bus.c_imag), 32'(m_im));
      check({tag, "_max_iter"}, 32'(bus.max_iter), 32'(m_it));
      check({tag, "_busy"}, 32'(bus.busy), 0);
      check({tag, "_drained"}, 32'(exp_q.size()), 0);
   endtask

   logic [7:0] fr[$];
   int p0;

   initial begin
      bus.uart_rxd = 1'b1;
      rst_n = 1'b0;
      repeat (5) @(negedge clk);
      check("rst_c_real", 32'(bus.c_real), 32'(RE0));
      check("rst_c_imag", 32'(bus.c_imag), 32'(IM0));
      check("rst_max_iter", 32'(bus.max_iter), 32'(IT0));
      check("rst_flags", {29'd0, bus.cfg_update, bus.rx_err, bus.busy}, 0);
      rst_n = 1'b1;
      repeat (2000) @(negedge clk);
      check("quiet_pulses", 32'(n_pulse), 0);
      post_check("idle");

      fr = '{8'hA5, 8'h01, 8'hC0, 8'h00, 8'h40, 8'h00, 8'h81};
      model_frame(fr);
      send_frame(fr);
      post_check("frame_c");

      fr = '{8'hA5, 8'h02, 8'hFF, 8'hFD};
      model_frame(fr);
      send_frame(fr);
      post_check("frame_iter");

      fr = '{8'hA5, 8'h02, 8'h10, 8'h00};
      model_frame(fr);
      send_frame(fr);
      post_check("bad_chk");

      push_err();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'hC0, 1'b1);
      send_byte(8'h00, 1'b0);
      repeat (2 * CPB) @(negedge clk);
      post_check("framing");
      fr = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
      model_frame(fr);
      send_frame(fr);
      post_check("after_framing");

      push_err();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h01, 1'b1);
      repeat (4) @(negedge clk);
      check("busy_mid_frame", 32'(bus.busy), 1);
      repeat (TMO + 500) @(negedge clk);
      post_check("timeout");

      p0 = n_pulse;
      bus.uart_rxd = 1'b0;
      repeat (4) @(negedge clk);
      bus.uart_rxd = 1'b1;
      repeat (100) @(negedge clk);
      check("glitch_pulses", 32'(n_pulse - p0), 0);
      post_check("glitch");

      send_byte(8'hA5, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'hC0, 1'b1);
      send_byte(8'h00, 1'b1);
      rst_n = 1'b0;
      m_re = RE0;
      m_im = IM0;
      m_it = IT0;
      repeat (3) @(negedge clk);
      check("midrst_c_real", 32'(bus.c_real), 32'(RE0));
      check("midrst_max_iter", 32'(bus.max_iter), 32'(IT0));
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      post_check("post_rst");
      fr = '{8'hA5, 8'h01, 8'h3F, 8'hFF, 8'hC0, 8'h01, 8'h01 ^ 8'h3F ^ 8'hFF ^ 8'hC0 ^ 8'h01};
      model_frame(fr);
      send_frame(fr);
      post_check("post_rst_frame");

      for (int k = 0; k < 20; k++) begin
         logic [7:0] cmd;
         logic [7:0] x;
         int n;
         case ($urandom_range(0, 5))
            0: cmd = 8'($urandom_range(3, 255));
            1, 2: cmd = 8'h02;
            default: cmd = 8'h01;
         endcase
         fr = '{8'hA5, cmd};
         if (cmd == 8'h01 || cmd == 8'h02) begin
            n = (cmd == 8'h01) ? 4 : 1;
            x = cmd;
            for (int i = 0; i < n; i++) begin
               fr.push_back(8'($urandom));
               x = x ^ fr[2 + i];
            end
            if ($urandom_range(0, 3) == 0) x = x ^ 8'($urandom_range(1, 255));
            fr.push_back(x);
         end else begin
            fr.push_back(8'h00);
         end
         if (cmd == 8'h01 || cmd == 8'h02) begin
            model_frame(fr);
            send_frame(fr);
         end else begin
            push_err();
            send_byte(fr[0], 1'b1);
            send_byte(fr[1], 1'b1);
         end
         repeat ($urandom_range(0, 40)) @(negedge clk);
         post_check("rand");
      end

      check("final_drain", 32'(exp_q.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
